// File: rtl/msft_dbg_fifo_drain.sv
// msft_dbg_fifo_drain: second initiator on the mmreg register port that polls the
// fast-printf debug FIFO, pops bytes through the DATA register and serialises them
// on an 8N1 UART line, with a byte strobe mirror for simulation monitors.
module msft_dbg_fifo_drain #(
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned CLKS_PER_BIT  = 16,
  parameter int unsigned POLL_INTERVAL = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  output logic        reg_en_o,
  output logic [31:0] reg_addr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ready_i,
  output logic        uart_tx_o,
  output logic        byte_valid_o,
  output logic [7:0]  byte_o,
  output logic        busy_o,
  output logic [15:0] empty_pop_o
);

  localparam logic [31:0] DATA_ADDR = BASE_ADDR + 32'h40;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h44;
  localparam int          PT_W      = $clog2(POLL_INTERVAL + 1);
  localparam int          CC_W      = $clog2(CLKS_PER_BIT);
  localparam logic [PT_W-1:0] PT_LAST = PT_W'(POLL_INTERVAL - 1);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STAT_REQ, S_STAT_RSP, S_WAIT, S_TX_WAIT, S_DATA_REQ, S_DATA_RSP
  } state_e;

  state_e          state_q;
  logic            reg_en_q;
  logic [31:0]     reg_addr_q;
  logic [4:0]      remaining_q;
  logic [PT_W-1:0] poll_tmr_q;
  logic            byte_valid_q;
  logic [7:0]      byte_q;
  logic [15:0]     empty_pop_q;

  logic            tx_q;
  logic            tx_active_q;
  logic [3:0]      bit_cnt_q;
  logic [CC_W-1:0] clk_cnt_q;
  logic [8:0]      shift_q;

  // A byte strobed this cycle is loaded into the UART at the next edge, so the
  // line counts as busy already while the strobe is high.
  logic uart_idle;
  assign uart_idle = !tx_active_q && !byte_valid_q;

  // Only the status depth, the data byte and the empty flag are meaningful.
  logic unused_rdata;
  assign unused_rdata = ^reg_rdata_i[31:9];

  // Poll/drain sequencer: one outstanding read at a time, outputs registered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      reg_en_q     <= 1'b0;
      reg_addr_q   <= '0;
      remaining_q  <= '0;
      poll_tmr_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      empty_pop_q  <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en_i) begin
            state_q    <= S_STAT_REQ;
            reg_en_q   <= 1'b1;
            reg_addr_q <= STAT_ADDR;
          end
        end
        S_STAT_REQ: begin
          if (reg_ready_i) begin
            reg_en_q <= 1'b0;
            state_q  <= S_STAT_RSP;
          end
        end
        S_STAT_RSP: begin
          remaining_q <= reg_rdata_i[4:0];
          if (reg_rdata_i[4:0] == 5'd0) begin
            poll_tmr_q <= '0;
            state_q    <= S_WAIT;
          end else begin
            state_q <= S_TX_WAIT;
          end
        end
        S_WAIT: begin
          if (poll_tmr_q == PT_LAST) begin
            poll_tmr_q <= '0;
            state_q    <= S_IDLE;
          end else begin
            poll_tmr_q <= poll_tmr_q + 1'b1;
          end
        end
        S_TX_WAIT: begin
          // Dropping the enable here leaves the unread bytes in the FIFO.
          if (!en_i) begin
            state_q <= S_IDLE;
          end else if (uart_idle) begin
            state_q    <= S_DATA_REQ;
            reg_en_q   <= 1'b1;
            reg_addr_q <= DATA_ADDR;
          end
        end
        S_DATA_REQ: begin
          if (reg_ready_i) begin
            reg_en_q <= 1'b0;
            state_q  <= S_DATA_RSP;
          end
        end
        S_DATA_RSP: begin
          if (reg_rdata_i[8]) begin
            // FIFO drained behind our back: count it and re-poll.
            if (empty_pop_q != 16'hFFFF) empty_pop_q <= empty_pop_q + 16'd1;
            state_q <= S_IDLE;
          end else begin
            byte_q       <= reg_rdata_i[7:0];
            byte_valid_q <= 1'b1;
            remaining_q  <= remaining_q - 5'd1;
            state_q      <= (remaining_q == 5'd1 || !en_i) ? S_IDLE : S_TX_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // 8N1 transmitter: start bit, 8 data bits LSB first, stop bit; the stop bit
  // sits at the top of the shift register so the line rests high after it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      bit_cnt_q   <= '0;
      clk_cnt_q   <= '0;
      shift_q     <= '0;
    end else if (byte_valid_q) begin
      tx_q        <= 1'b0;
      tx_active_q <= 1'b1;
      bit_cnt_q   <= '0;
      clk_cnt_q   <= '0;
      shift_q     <= {1'b1, byte_q};
    end else if (tx_active_q) begin
      if (clk_cnt_q == CC_LAST) begin
        clk_cnt_q <= '0;
        if (bit_cnt_q == 4'd9) begin
          tx_active_q <= 1'b0;
        end else begin
          tx_q      <= shift_q[0];
          shift_q   <= {1'b1, shift_q[8:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else begin
        clk_cnt_q <= clk_cnt_q + 1'b1;
      end
    end
  end

  assign reg_en_o     = reg_en_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_we_o     = 1'b0;
  assign reg_wdata_o  = 32'h0;
  assign uart_tx_o    = tx_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign empty_pop_o  = empty_pop_q;
  assign busy_o       = (state_q != S_IDLE && state_q != S_WAIT) || tx_active_q || byte_valid_q;

endmodule
